// File: rtl/zipocpu_core.sv
// zipocpu_core: minimal 64-bit multi-cycle processor with one shared memory port.
// Each instruction takes two cycles: FETCH reads the instruction word at pc,
// EXEC performs the ALU / load / store / branch and writes back on its edge.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   rw         memory direction (0 = read, 1 = write)
//   addr       word address for fetch, load and store
//   byte_write store data, forced to zero when rw = 0
//   byte_read  combinational read data from the RAM at addr
//
// addr/rw/byte_write depend on registered state only, so the RAM's
// combinational read path can never loop back into them.
module zipocpu_core #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rw,
    output logic [63:0] addr,
    output logic [63:0] byte_write,
    input  logic [63:0] byte_read
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_LD   = 8'h07;
    localparam logic [7:0] OP_ST   = 8'h08;
    localparam logic [7:0] OP_JMP  = 8'h09;
    localparam logic [7:0] OP_BEQZ = 8'h0A;
    localparam logic [7:0] OP_HALT = 8'h0B;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_r;
    logic [63:0] pc_r;
    logic [63:0] ir_r;
    logic [63:0] regs_r [0:7];

    logic [7:0]  op_s;
    logic [2:0]  rd_idx_s;
    logic [2:0]  rs_idx_s;
    logic [63:0] simm_s;
    logic [63:0] rd_val_s;
    logic [63:0] rs_val_s;
    logic [63:0] alu_res_s;
    logic        wr_en_s;
    logic        jump_s;

    // Instruction field decode; r0 is forced to read as zero.
    always_comb begin
        op_s     = ir_r[63:56];
        rd_idx_s = ir_r[55:53];
        rs_idx_s = ir_r[52:50];
        simm_s   = {{32{ir_r[31]}}, ir_r[31:0]};
        if (rd_idx_s == 3'd0) begin
            rd_val_s = 64'd0;
        end else begin
            rd_val_s = regs_r[rd_idx_s];
        end
        if (rs_idx_s == 3'd0) begin
            rs_val_s = 64'd0;
        end else begin
            rs_val_s = regs_r[rs_idx_s];
        end
    end

    // Write-back value and branch decision for the instruction held in ir.
    always_comb begin
        alu_res_s = rd_val_s;
        wr_en_s   = 1'b0;
        jump_s    = 1'b0;
        case (op_s)
            OP_LDI: begin
                alu_res_s = simm_s;
                wr_en_s   = 1'b1;
            end
            OP_ADD: begin
                alu_res_s = rd_val_s + rs_val_s;
                wr_en_s   = 1'b1;
            end
            OP_SUB: begin
                alu_res_s = rd_val_s - rs_val_s;
                wr_en_s   = 1'b1;
            end
            OP_AND: begin
                alu_res_s = rd_val_s & rs_val_s;
                wr_en_s   = 1'b1;
            end
            OP_OR: begin
                alu_res_s = rd_val_s | rs_val_s;
                wr_en_s   = 1'b1;
            end
            OP_XOR: begin
                alu_res_s = rd_val_s ^ rs_val_s;
                wr_en_s   = 1'b1;
            end
            OP_LD: begin
                alu_res_s = byte_read;
                wr_en_s   = 1'b1;
            end
            OP_JMP: begin
                jump_s = 1'b1;
            end
            OP_BEQZ: begin
                jump_s = (rd_val_s == 64'd0);
            end
            OP_NOP, OP_ST, OP_HALT: begin
                alu_res_s = rd_val_s;
            end
            default: begin
                alu_res_s = rd_val_s;
            end
        endcase
    end

    // Core state machine: fetch, execute/write-back, and the parked HALT state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            ir_r    <= 64'd0;
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= 64'd0;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    ir_r    <= byte_read;
                    pc_r    <= pc_r + 64'd1;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (wr_en_s && (rd_idx_s != 3'd0)) begin
                        regs_r[rd_idx_s] <= alu_res_s;
                    end
                    if (jump_s) begin
                        pc_r <= simm_s;
                    end
                    if (op_s == OP_HALT) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    // Memory port drive. During a non-memory EXEC, addr keeps showing the
    // address of the executing instruction (pc has already advanced by one).
    always_comb begin
        rw         = 1'b0;
        addr       = pc_r;
        byte_write = 64'd0;
        case (state_r)
            ST_FETCH: begin
                addr = pc_r;
            end
            ST_EXEC: begin
                if (op_s == OP_LD) begin
                    addr = simm_s;
                end else if (op_s == OP_ST) begin
                    addr       = simm_s;
                    rw         = 1'b1;
                    byte_write = rs_val_s;
                end else begin
                    addr = pc_r - 64'd1;
                end
            end
            ST_HALT: begin
                addr = pc_r;
            end
            default: begin
                addr = pc_r;
            end
        endcase
    end

endmodule

// File: tb/tb_zipocpu_core.sv
// Directed bench for zipocpu_core. Programs are loaded into a bench-side RAM,
// the expected per-cycle port trace is queued as each program is set up, and
// the queue is drained and compared at the falling edge while the core runs.
module tb_zipocpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rw;
    logic [63:0] addr;
    logic [63:0] byte_write;
    logic [63:0] byte_read;

    logic [63:0] mem [0:4095];

    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    logic [63:0] exp_addr_q[$];
    logic        exp_rw_q[$];
    logic [63:0] exp_bw_q[$];

    zipocpu_core #(.RESET_PC(64'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rw         (rw),
        .addr       (addr),
        .byte_write (byte_write),
        .byte_read  (byte_read)
    );

    always #5 clk = ~clk;

    assign byte_read = (addr < 64'd4096) ? mem[addr[11:0]] : 64'd0;

    always @(posedge clk) begin
        if (rw && (addr < 64'd4096)) mem[addr[11:0]] <= byte_write;
    end

    function automatic logic [63:0] enc(input logic [7:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [31:0] imm);
        return {op, rd, rs, 18'd0, imm};
    endfunction

    task automatic chk64(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: observed %h expected %h", tag, name, obs, exp);
        end
    endtask

    task automatic expect_cyc(input logic [63:0] a, input logic r, input logic [63:0] b);
        exp_addr_q.push_back(a);
        exp_rw_q.push_back(r);
        exp_bw_q.push_back(b);
    endtask

    // Plain instruction: FETCH and EXEC both show its own address.
    task automatic expect_plain(input logic [63:0] a);
        expect_cyc(a, 1'b0, 64'd0);
        expect_cyc(a, 1'b0, 64'd0);
    endtask

    // Compare current outputs against the queue head, then advance a cycle.
    task automatic run_check(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
            end else begin
                chk64("addr", addr, exp_addr_q.pop_front());
                chk64("rw", {63'd0, rw}, {63'd0, exp_rw_q.pop_front()});
                chk64("byte_write", byte_write, exp_bw_q.pop_front());
            end
            @(negedge clk);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
    endtask

    // Hold reset for three edges, check reset outputs, release at negedge.
    task automatic reset_core();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk64("reset_addr", addr, 64'd0);
        chk64("reset_rw", {63'd0, rw}, 64'd0);
        chk64("reset_bw", byte_write, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        // ---- Sequential fetch: 4 NOPs then HALT ----
        tag = "seq";
        rst_n = 1'b0;
        clear_mem();
        mem[4] = enc(8'h0B, 3'd0, 3'd0, 32'd0);
        reset_core();
        for (int i = 0; i < 5; i++) expect_plain(64'(i));
        expect_cyc(64'd5, 1'b0, 64'd0);
        expect_cyc(64'd5, 1'b0, 64'd0);
        expect_cyc(64'd5, 1'b0, 64'd0);
        run_check(13);

        // ---- ALU and store ----
        tag = "alu";
        rst_n = 1'b0;
        clear_mem();
        mem[0] = enc(8'h01, 3'd1, 3'd0, 32'd5);            // LDI r1,5
        mem[1] = enc(8'h01, 3'd2, 3'd0, 32'hFFFF_FFFD);    // LDI r2,-3
        mem[2] = enc(8'h02, 3'd1, 3'd2, 32'd0);            // ADD r1,r2
        mem[3] = enc(8'h08, 3'd0, 3'd1, 32'h100);          // ST r1,[0x100]
        mem[4] = enc(8'h03, 3'd2, 3'd1, 32'd0);            // SUB r2,r1
        mem[5] = enc(8'h08, 3'd0, 3'd2, 32'h101);          // ST r2,[0x101]
        mem[6] = enc(8'h02, 3'd2, 3'd2, 32'd0);            // ADD r2,r2
        mem[7] = enc(8'h08, 3'd0, 3'd2, 32'h102);          // ST r2,[0x102]
        mem[8] = enc(8'h0B, 3'd0, 3'd0, 32'd0);            // HALT
        reset_core();
        expect_plain(64'd0);
        expect_plain(64'd1);
        expect_plain(64'd2);
        expect_cyc(64'd3, 1'b0, 64'd0);
        expect_cyc(64'h100, 1'b1, 64'd2);
        expect_plain(64'd4);
        expect_cyc(64'd5, 1'b0, 64'd0);
        expect_cyc(64'h101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        expect_plain(64'd6);
        expect_cyc(64'd7, 1'b0, 64'd0);
        expect_cyc(64'h102, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
        expect_plain(64'd8);
        expect_cyc(64'd9, 1'b0, 64'd0);
        run_check(19);
        chk64("mem100", mem[12'h100], 64'd2);
        chk64("mem101", mem[12'h101], 64'hFFFF_FFFF_FFFF_FFFB);

        // ---- Load, plus a sign-extended high address ----
        tag = "load";
        rst_n = 1'b0;
        clear_mem();
        mem[12'h40] = 64'hDEADBEEF_00000001;
        mem[0] = enc(8'h07, 3'd3, 3'd0, 32'h40);           // LD r3,[0x40]
        mem[1] = enc(8'h08, 3'd0, 3'd3, 32'h41);           // ST r3,[0x41]
        mem[2] = enc(8'h07, 3'd5, 3'd0, 32'h8000_0010);    // LD r5,[high]
        mem[3] = enc(8'h0B, 3'd0, 3'd0, 32'd0);            // HALT
        reset_core();
        expect_cyc(64'd0, 1'b0, 64'd0);
        expect_cyc(64'h40, 1'b0, 64'd0);
        expect_cyc(64'd1, 1'b0, 64'd0);
        expect_cyc(64'h41, 1'b1, 64'hDEADBEEF_00000001);
        expect_cyc(64'd2, 1'b0, 64'd0);
        expect_cyc(64'hFFFF_FFFF_8000_0010, 1'b0, 64'd0);
        expect_plain(64'd3);
        expect_cyc(64'd4, 1'b0, 64'd0);
        run_check(9);
        chk64("mem41", mem[12'h41], 64'hDEADBEEF_00000001);

        // ---- Branches: taken BEQZ, not-taken BEQZ, r0 discard, JMP 0 ----
        tag = "branch";
        rst_n = 1'b0;
        clear_mem();
        mem[0]     = enc(8'h01, 3'd4, 3'd0, 32'd0);        // LDI r4,0
        mem[1]     = enc(8'h0A, 3'd4, 3'd0, 32'h10);       // BEQZ r4,0x10
        mem[12'h10] = enc(8'h01, 3'd4, 3'd0, 32'd1);       // LDI r4,1
        mem[12'h11] = enc(8'h0A, 3'd4, 3'd0, 32'h20);      // BEQZ r4,0x20
        mem[12'h12] = enc(8'h01, 3'd0, 3'd0, 32'd7);       // LDI r0,7
        mem[12'h13] = enc(8'h0A, 3'd0, 3'd0, 32'h30);      // BEQZ r0,0x30
        mem[12'h20] = enc(8'h0B, 3'd0, 3'd0, 32'd0);       // HALT (wrong path)
        mem[12'h30] = enc(8'h09, 3'd0, 3'd0, 32'd0);       // JMP 0
        reset_core();
        expect_plain(64'd0);
        expect_plain(64'd1);
        expect_plain(64'h10);
        expect_plain(64'h11);
        expect_plain(64'h12);
        expect_plain(64'h13);
        expect_plain(64'h30);
        expect_plain(64'd0);
        expect_plain(64'd1);
        expect_cyc(64'h10, 1'b0, 64'd0);
        run_check(19);

        // ---- Reset in the EXEC of an ADD ----
        tag = "midreset";
        rst_n = 1'b0;
        clear_mem();
        mem[0] = enc(8'h08, 3'd0, 3'd1, 32'h50);           // ST r1,[0x50]
        mem[1] = enc(8'h01, 3'd1, 3'd0, 32'd9);            // LDI r1,9
        mem[2] = enc(8'h02, 3'd1, 3'd1, 32'd0);            // ADD r1,r1
        mem[3] = enc(8'h08, 3'd0, 3'd1, 32'h51);           // ST r1,[0x51]
        mem[4] = enc(8'h0B, 3'd0, 3'd0, 32'd0);            // HALT
        reset_core();
        expect_cyc(64'd0, 1'b0, 64'd0);
        expect_cyc(64'h50, 1'b1, 64'd0);
        expect_plain(64'd1);
        expect_cyc(64'd2, 1'b0, 64'd0);
        run_check(5);
        expect_cyc(64'd2, 1'b0, 64'd0);   // EXEC of ADD, reset asserted now
        rst_n = 1'b0;
        run_check(1);
        chk64("post_reset_addr", addr, 64'd0);
        reset_core();
        chk64("mem51_unwritten", mem[12'h51], 64'd0);
        expect_cyc(64'd0, 1'b0, 64'd0);
        expect_cyc(64'h50, 1'b1, 64'd0);
        expect_plain(64'd1);
        expect_plain(64'd2);
        expect_cyc(64'd3, 1'b0, 64'd0);
        expect_cyc(64'h51, 1'b1, 64'd18);
        expect_plain(64'd4);
        expect_cyc(64'd5, 1'b0, 64'd0);
        run_check(11);
        chk64("mem51", mem[12'h51], 64'd18);

        chk64("queue_drained", 64'(exp_addr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zipocpu_core.md
# zipocpu_core

Minimal 64-bit multi-cycle processor core with one shared memory port. It fetches 64-bit instruction words and executes register ALU, load/store and branch operations. It sits between the system clock/reset and a word-addressed RAM whose read data is combinational. The simulation environment ends a run when `addr` reaches the memory-end address.

## Interface
- `RESET_PC`, default 64'h0: fetch address after reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rw`  out  1  memory direction: 0 = read, 1 = write. RAM writes `byte_write` to `addr` on the rising edge while `rw`=1.
- `addr`  out  64  word address for fetch, load and store.
- `byte_write`  out  64  store data.
- `byte_read`  in  64  read data. Combinational from `addr`, valid in the same cycle.

## Operation
- State:
  - `pc` (64 bits).
  - `ir` (64 bits).
  - Register file r0..r7, each 64 bits. r0 reads as 0 and ignores writes.
  - FSM states FETCH, EXEC, HALT.
- Instruction word fields:
  - `op` = [63:56]
  - `rd` = [55:53]
  - `rs` = [52:50]
  - `imm` = [31:0], sign-extended to 64 bits (`simm`).
  - Bits [49:32] are ignored.
- Opcodes (all arithmetic is modulo 2^64):
  - 0x00 NOP
  - 0x01 LDI: rd = simm
  - 0x02 ADD: rd = rd + rs
  - 0x03 SUB: rd = rd − rs
  - 0x04 AND
  - 0x05 OR
  - 0x06 XOR
  - 0x07 LD: rd = mem[simm]
  - 0x08 ST: mem[simm] = rs
  - 0x09 JMP: pc = simm
  - 0x0A BEQZ: if rd == 0 then pc = simm
  - 0x0B HALT
  - Any other opcode executes as NOP.
- FETCH:
  - `addr` = pc, `rw` = 0.
  - On the edge: ir ← `byte_read`, pc ← pc + 1 (wraps from all-ones to 0), go to EXEC.
- EXEC:
  - ALU/LDI ops write rd; then go to FETCH.
  - LD: `addr` = simm, `rw` = 0; rd ← `byte_read` on the edge.
  - ST: `addr` = simm, `rw` = 1, `byte_write` = rs.
  - JMP/BEQZ: update pc (which already holds the incremented value) when taken.
  - HALT: go to HALT.
  - All non-HALT instructions return to FETCH.
- HALT:
  - `addr` = pc, which is the address following the HALT instruction.
  - `rw` = 0; state is held until reset.
- Output drive:
  - `addr`, `rw` and `byte_write` are combinational functions of registered state only. There is no combinational path from `byte_read`.
  - `byte_write` = 0 whenever `rw` = 0.

## Timing
- Reset: when `rst_n` = 0 at a rising edge:
  - pc ← RESET_PC, ir ← 0, all registers ← 0, state ← FETCH.
  - Resulting outputs: `addr` = RESET_PC, `rw` = 0, `byte_write` = 0.
- Reset takes priority over any in-progress instruction. A ST in EXEC while `rst_n` = 0 still presents `rw` = 1 for that cycle. The RAM may therefore commit the write, and this is permitted.
- Every instruction takes exactly 2 cycles (FETCH + EXEC), including LD and ST. HALT takes 2 cycles and then parks the core.
- Write-back happens at the EXEC edge. The next instruction's FETCH sees the updated registers.
- ADD rd, rd (same source and destination) uses the old rd value.
- A branch target takes effect at the next FETCH; there is no delay slot.
- `rd` = r0: the write is discarded. BEQZ r0 is always taken.
- LD/ST to address simm with bit 31 set sign-extends to a high address. This is legal and there is no exception.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with RESET_PC = 0 → `addr` = 0, `rw` = 0, `byte_write` = 0. First FETCH occurs at address 0 on the cycle after release.
- Sequential fetch: program of 4 NOPs then HALT → `addr` sequence 0,0,1,1,2,2,3,3,4,4, then holds 5. `rw` stays 0 throughout.
- ALU and store:
  - Program: LDI r1,5; LDI r2,−3; ADD r1,r2; ST r1,[0x100].
  - Required: write cycle with `addr` = 0x100, `rw` = 1, `byte_write` = 2.
  - SUB r2,r1 then ST r2,[0x101] → `byte_write` = 64'hFFFF_FFFF_FFFF_FFFB.
- Load: mem[0x40] = 64'hDEADBEEF_00000001; LD r3,[0x40]; ST r3,[0x41] → mem[0x41] holds the same value. The LD cycle shows `addr` = 0x40 with `rw` = 0.
- Branch:
  - LDI r4,0; BEQZ r4,0x10 → next FETCH `addr` = 0x10.
  - LDI r4,1; BEQZ r4,0x10 → falls through.
  - JMP 0 loops back to `addr` = 0.
- Reset mid-program: assert `rst_n` = 0 during the EXEC of an ADD → rd is not written. Registers clear and fetch restarts at RESET_PC.
